// File: rtl/icache_axi_rd_bridge.sv
// Instruction-cache refill bridge: one line request becomes a single INCR
// burst on AXI AR, and R beats are returned to the cache one cycle later.
module icache_axi_rd_bridge #(
    parameter logic [3:0] AXI_ID     = 4'd0,
    parameter int         LINE_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r_req,
    input  logic [31:0] r_addr,
    output logic        r_rdy,
    input  logic        r_data_ready,
    output logic        ret_valid,
    output logic        ret_last,
    output logic [31:0] r_data_AXI,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        bus_err,
    output logic        proto_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

    localparam logic [3:0] LAST_CNT = 4'(LINE_WORDS - 1);

    state_t      state_q, state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        bus_err_q, bus_err_d;
    logic        proto_err_q, proto_err_d;
    logic        ret_valid_q, ret_valid_d;
    logic        ret_last_q, ret_last_d;
    logic [31:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            araddr_q    <= '0;
            cnt_q       <= '0;
            bus_err_q   <= 1'b0;
            proto_err_q <= 1'b0;
            ret_valid_q <= 1'b0;
            ret_last_q  <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            cnt_q       <= cnt_d;
            bus_err_q   <= bus_err_d;
            proto_err_q <= proto_err_d;
            ret_valid_q <= ret_valid_d;
            ret_last_q  <= ret_last_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        araddr_d    = araddr_q;
        cnt_d       = cnt_q;
        bus_err_d   = bus_err_q;
        proto_err_d = proto_err_q;
        ret_valid_d = 1'b0;
        ret_last_d  = 1'b0;
        rdata_d     = rdata_q;
        arvalid     = 1'b0;
        r_rdy       = 1'b0;
        rready      = 1'b0;
        case (state_q)
            IDLE: begin
                if (r_req) begin
                    araddr_d    = r_addr & 32'hFFFF_FFC0;
                    bus_err_d   = 1'b0;
                    proto_err_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                arvalid = 1'b1;
                r_rdy   = arready;
                if (arready) state_d = DATA;
            end
            DATA: begin
                rready = r_data_ready;
                if (rvalid && r_data_ready) begin
                    rdata_d     = rdata;
                    ret_valid_d = 1'b1;
                    cnt_d       = cnt_q + 4'd1;
                    if (rresp != 2'b00) bus_err_d = 1'b1;
                    // The line ends on whichever comes first: rlast or the 16th beat.
                    if (rlast || cnt_q == LAST_CNT) begin
                        ret_last_d = 1'b1;
                        state_d    = IDLE;
                        if (rlast != (cnt_q == LAST_CNT)) proto_err_d = 1'b1;
                        if (!rlast) state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Slave overran the line; swallow beats until it closes the burst.
                rready = 1'b1;
                if (rvalid && rlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign araddr     = araddr_q;
    assign arid       = AXI_ID;
    assign arlen      = 8'(LINE_WORDS - 1);
    assign arsize     = 3'b010;
    assign arburst    = 2'b01;
    assign ret_valid  = ret_valid_q;
    assign ret_last   = ret_last_q;
    assign r_data_AXI = rdata_q;
    assign bus_err    = bus_err_q;
    assign proto_err  = proto_err_q;
endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed bench for icache_axi_rd_bridge: a line-level refill model checks
// every output on every cycle, plus literal expectations per scenario.
module tb_icache_axi_rd_bridge;
    logic        clk = 1'b0;
    logic        rst, r_req, r_data_ready, arready, rlast, rvalid;
    logic [31:0] r_addr, rdata;
    logic [1:0]  rresp;
    logic        r_rdy, ret_valid, ret_last, arvalid, rready, bus_err, proto_err;
    logic [31:0] r_data_AXI, araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    int checks = 0;
    int failures = 0;

    icache_axi_rd_bridge dut (
        .clk(clk), .rst(rst), .r_req(r_req), .r_addr(r_addr), .r_rdy(r_rdy),
        .r_data_ready(r_data_ready), .ret_valid(ret_valid), .ret_last(ret_last),
        .r_data_AXI(r_data_AXI), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .bus_err(bus_err), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Line-level model: where the refill is (address phase, collecting words,
    // draining an overrun) and what the cache must see next cycle.
    bit          m_ar = 0, m_line = 0, m_drain = 0;
    int          m_beats = 0;
    logic [31:0] m_addr = '0, m_word = '0;
    bit          m_bus = 0, m_perr = 0, m_rv = 0, m_rl = 0;

    // Observed return stream, for the literal per-scenario checks.
    int          ret_cnt = 0, last_cnt = 0;
    logic [31:0] got[$];

    always @(negedge clk) begin
        bit e_rready;
        e_rready = m_line ? r_data_ready : m_drain;
        chk("arvalid", arvalid, m_ar);
        chk("araddr", araddr, m_addr);
        chk("r_rdy", r_rdy, m_ar & arready);
        chk("rready", rready, e_rready);
        chk("ret_valid", ret_valid, m_rv);
        chk("ret_last", ret_last, m_rl);
        chk("r_data_AXI", r_data_AXI, m_word);
        chk("bus_err", bus_err, m_bus);
        chk("proto_err", proto_err, m_perr);
        chk("arlen", arlen, 32'd15);
        chk("arsize", arsize, 32'd2);
        chk("arburst", arburst, 32'd1);
        chk("arid", arid, 32'd0);
        if (ret_valid) begin
            ret_cnt++;
            got.push_back(r_data_AXI);
            if (ret_last) last_cnt++;
        end
        if (rst) begin
            m_ar = 0; m_line = 0; m_drain = 0; m_beats = 0; m_addr = '0; m_word = '0;
            m_bus = 0; m_perr = 0; m_rv = 0; m_rl = 0;
        end else begin
            m_rv = 0; m_rl = 0;
            if (!m_ar && !m_line && !m_drain) begin
                if (r_req) begin
                    m_ar = 1; m_addr = {r_addr[31:6], 6'd0}; m_bus = 0; m_perr = 0; m_beats = 0;
                end
            end else if (m_ar) begin
                if (arready) begin m_ar = 0; m_line = 1; end
            end else if (m_line) begin
                if (rvalid && r_data_ready) begin
                    m_beats++;
                    m_rv = 1; m_word = rdata;
                    if (rresp != 2'b00) m_bus = 1;
                    if (rlast || m_beats == 16) begin
                        m_rl = 1; m_line = 0;
                        if (rlast && m_beats < 16) m_perr = 1;
                        if (!rlast) begin m_perr = 1; m_drain = 1; end
                    end
                end
            end else if (rvalid && rlast) begin
                m_drain = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a request and hold arready low for 'stall' AR cycles.
    task automatic do_req(input logic [31:0] addr, input int stall);
        r_req = 1; r_addr = addr; arready = 0;
        step();
        r_req = 0;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("stall_arvalid", arvalid, 1);
            chk("stall_araddr", araddr, addr & 32'hFFFF_FFC0);
            chk("stall_r_rdy", r_rdy, 0);
            step();
        end
        arready = 1;
        @(negedge clk);
        chk("hs_r_rdy", r_rdy, 1);
        chk("hs_araddr", araddr, addr & 32'hFFFF_FFC0);
        step();
        arready = 0;
    endtask

    // Offer n beats (data = beat index); rlast on beat last_at, SLVERR on err_at.
    task automatic r_beats(input int n, input int last_at, input int err_at, input bit toggle);
        int i = 0;
        int guard = 0;
        bit acc;
        while (i < n && guard < 200) begin
            rvalid = 1; rdata = 32'(i); rlast = (i == last_at);
            rresp = (i == err_at) ? 2'b10 : 2'b00;
            if (toggle) r_data_ready = guard[0];
            @(negedge clk);
            acc = rready;
            step();
            if (acc) i++;
            guard++;
        end
        if (i < n) begin
            failures++;
            $display("FAIL r_beats_timeout accepted=%0d required=%0d", i, n);
        end
        rvalid = 0; rlast = 0; rresp = 0; r_data_ready = 1;
    endtask

    initial begin
        int n0, l0;
        rst = 1; r_req = 0; r_addr = '0; r_data_ready = 1; arready = 0;
        rlast = 0; rvalid = 0; rdata = '0; rresp = '0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_ret_valid", ret_valid, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 15);
        rst = 0;
        step();

        // Basic refill
        n0 = ret_cnt; l0 = last_cnt;
        do_req(32'h1C00_0044, 0);
        r_beats(16, 15, -1, 0);
        repeat (2) step();
        chk("basic_count", ret_cnt - n0, 16);
        chk("basic_first", got[n0], 0);
        chk("basic_lastword", got[n0 + 15], 15);
        chk("basic_lasts", last_cnt - l0, 1);
        chk("basic_errs", {bus_err, proto_err}, 0);

        // AR stall, then back-pressure with toggling cache ready
        n0 = ret_cnt;
        do_req(32'h0000_1234, 5);
        r_beats(16, 15, -1, 1);
        repeat (2) step();
        chk("bp_count", ret_cnt - n0, 16);
        chk("bp_word7", got[n0 + 7], 7);
        chk("bp_word15", got[n0 + 15], 15);

        // Response error on beat 7, cleared by next request
        n0 = ret_cnt;
        do_req(32'hABCD_EF7F, 0);
        r_beats(16, 15, 7, 0);
        repeat (2) step();
        chk("slverr_bus_err", bus_err, 1);
        chk("slverr_count", ret_cnt - n0, 16);

        // Early rlast on beat 10 (word 10)
        n0 = ret_cnt; l0 = last_cnt;
        do_req(32'h0000_0080, 0);
        chk("clear_bus_err", bus_err, 0);
        r_beats(11, 10, -1, 0);
        repeat (2) step();
        chk("early_count", ret_cnt - n0, 11);
        chk("early_lastword", got[n0 + 10], 10);
        chk("early_lasts", last_cnt - l0, 1);
        chk("early_proto", proto_err, 1);

        // Missing rlast: two extra beats are drained
        n0 = ret_cnt;
        do_req(32'h0000_0100, 0);
        r_beats(18, 17, -1, 0);
        repeat (2) step();
        chk("drain_count", ret_cnt - n0, 16);
        chk("drain_proto", proto_err, 1);
        chk("drain_word", r_data_AXI, 15);

        // Reset after beat 5, then a clean line
        do_req(32'h0000_0200, 0);
        r_beats(6, -1, -1, 0);
        rst = 1;
        step();
        @(negedge clk);
        chk("mid_rst_ret_valid", ret_valid, 0);
        chk("mid_rst_rready", rready, 0);
        chk("mid_rst_data", r_data_AXI, 0);
        chk("mid_rst_araddr", araddr, 0);
        rst = 0;
        step();
        n0 = ret_cnt;
        do_req(32'h0000_0300, 0);
        r_beats(16, 15, -1, 0);
        repeat (2) step();
        chk("post_rst_count", ret_cnt - n0, 16);
        chk("post_rst_errs", {bus_err, proto_err}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
